// File: rtl/fetch_buffer_if.sv
// Handshake bundle between the IF stage (producer), the fetch buffer and the
// decode stage (consumer). The buffer side uses the slave modport; whatever
// drives fetched records and consumes decoded ones uses the master modport.
interface fetch_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_inst;
  logic [31:0]   in_pc;
  logic [31:0]   in_pc4;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_inst;
  logic [31:0]   out_pc;
  logic [31:0]   out_pc4;
  logic [CW-1:0] count;

  modport slave (
    input  flush,
    input  in_valid,
    output in_ready,
    input  in_inst,
    input  in_pc,
    input  in_pc4,
    output out_valid,
    input  out_ready,
    output out_inst,
    output out_pc,
    output out_pc4,
    output count
  );

  modport master (
    output flush,
    output in_valid,
    input  in_ready,
    output in_inst,
    output in_pc,
    output in_pc4,
    input  out_valid,
    output out_ready,
    input  out_inst,
    input  out_pc,
    input  out_pc4,
    input  count
  );
endinterface

// File: rtl/fetch_buffer.sv
// Fetch buffer: a small circular queue of {inst, pc, pc4} records that sits
// between instruction fetch and decode. Decode stalls are absorbed until the
// queue fills; a branch redirect (flush) empties the queue in one cycle.
// The head record is read straight from storage, so there is no
// combinational path from the fetch inputs to the decode outputs.
module fetch_buffer #(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_buffer_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [95:0]   mem_q [DEPTH];
  logic          push;
  logic          pop;

  // A full buffer never accepts, even if the head is popped this cycle;
  // holding in_ready low during reset keeps IF from handing over records
  // that would be lost.
  assign bus.in_ready  = (count_q != CW'(DEPTH)) & rst_n;
  assign bus.out_valid = (count_q != '0);
  assign bus.count     = count_q;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  assign {bus.out_inst, bus.out_pc, bus.out_pc4} = mem_q[rd_ptr_q];

  // Next-state pointers and occupancy; flush discards everything, including
  // any push or pop happening in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers; reset behaves like a flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Record storage is deliberately not reset; a flushed push is not written.
  always_ff @(posedge clk) begin
    if (push && !bus.flush) begin
      mem_q[wr_ptr_q] <= {bus.in_inst, bus.in_pc, bus.in_pc4};
    end
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer. Accepted records are pushed into a
// scoreboard queue and compared against the head when decode consumes them.
module tb_fetch_buffer;
  localparam int DEPTH = 4;

  logic clk;
  logic rst_n;

  fetch_buffer_if #(.DEPTH(DEPTH)) bus ();

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int nAssert = 0;
  int nFail   = 0;
  logic [95:0] exp[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and update the reference model from the inputs as they
  // were at the edge; outputs are then settled 1 time unit after the edge.
  task automatic tick();
    logic doPush, doPop;
    doPush = bus.in_valid && rst_n && (exp.size() != DEPTH);
    doPop  = (exp.size() != 0) && bus.out_ready;
    @(posedge clk);
    if (!rst_n || bus.flush) begin
      exp.delete();
    end else begin
      if (doPop)  void'(exp.pop_front());
      if (doPush) exp.push_back({bus.in_inst, bus.in_pc, bus.in_pc4});
    end
    #1;
  endtask

  task automatic setRec(input logic [31:0] pc);
    bus.in_inst = $urandom;
    bus.in_pc   = pc;
    bus.in_pc4  = pc + 32'd4;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    setRec(32'h0);
    tick();
    tick();
    nAssert++;
    if (bus.count !== 3'd0) begin
      nFail++; $display("FAIL reset_count: got %0d want 0", bus.count);
    end
    nAssert++;
    if (bus.out_valid !== 1'b0) begin
      nFail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    nAssert++;
    if (bus.in_ready !== 1'b0) begin
      nFail++; $display("FAIL reset_in_ready_low: got %b want 0", bus.in_ready);
    end
    rst_n = 1'b1;
    #1;
    nAssert++;
    if (bus.in_ready !== 1'b1) begin
      nFail++; $display("FAIL reset_in_ready_release: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_single();
    bus.in_valid = 1'b1;
    bus.in_inst  = 32'h0050_0093;
    bus.in_pc    = 32'h0;
    bus.in_pc4   = 32'h4;
    tick();
    bus.in_valid = 1'b0;
    nAssert++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.count !== 3'd1) begin
      nFail++; $display("FAIL single_head: got valid=%b pc=%h count=%0d want valid=1 pc=0 count=1",
                        bus.out_valid, bus.out_pc, bus.count);
    end
    nAssert++;
    if ({bus.out_inst, bus.out_pc, bus.out_pc4} !== {32'h0050_0093, 32'h0, 32'h4}) begin
      nFail++; $display("FAIL single_record: got %h %h %h want 00500093 0 4",
                        bus.out_inst, bus.out_pc, bus.out_pc4);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    nAssert++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
      nFail++; $display("FAIL single_pop: got count=%0d valid=%b want 0 0", bus.count, bus.out_valid);
    end
  endtask

  task automatic test_fill_full();
    bus.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      bus.in_valid = 1'b1;
      setRec(32'(4 * i));
      tick();
    end
    nAssert++;
    if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin
      nFail++; $display("FAIL full_state: got count=%0d in_ready=%b want 4 0", bus.count, bus.in_ready);
    end
    setRec(32'h10);
    tick();
    bus.in_valid = 1'b0;
    nAssert++;
    if (bus.count !== 3'd4) begin
      nFail++; $display("FAIL full_reject: got count=%0d want 4", bus.count);
    end
    for (int i = 0; i < DEPTH; i++) begin
      nAssert++;
      if (bus.out_valid !== 1'b1 || {bus.out_inst, bus.out_pc, bus.out_pc4} !== exp[0]
          || bus.out_pc !== 32'(4 * i)) begin
        nFail++; $display("FAIL full_drain_%0d: got pc=%h valid=%b want pc=%h valid=1",
                          i, bus.out_pc, bus.out_valid, 4 * i);
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      if (i == 0) begin
        nAssert++;
        if (bus.in_ready !== 1'b1) begin
          nFail++; $display("FAIL full_ready_return: got %b want 1", bus.in_ready);
        end
      end
    end
    nAssert++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
      nFail++; $display("FAIL full_empty: got count=%0d valid=%b want 0 0", bus.count, bus.out_valid);
    end
  endtask

  task automatic test_wrap();
    int idx = 0;
    int received = 0;
    for (int cyc = 0; cyc < 200 && received < 10; cyc++) begin
      bus.in_valid = (idx < 10);
      setRec(32'h100 + 32'(4 * idx));
      bus.out_ready = 1'($urandom_range(0, 1));
      nAssert++;
      if (bus.count !== 3'(exp.size()) || bus.count > 3'd4) begin
        nFail++; $display("FAIL wrap_count: got %0d want %0d", bus.count, exp.size());
      end
      if (exp.size() != 0 && bus.out_ready) begin
        nAssert++;
        if (bus.out_valid !== 1'b1 || {bus.out_inst, bus.out_pc, bus.out_pc4} !== exp[0]
            || bus.out_pc !== 32'h100 + 32'(4 * received)) begin
          nFail++; $display("FAIL wrap_order_%0d: got pc=%h valid=%b want pc=%h",
                            received, bus.out_pc, bus.out_valid, 32'h100 + 32'(4 * received));
        end
        received++;
      end
      if (bus.in_valid && exp.size() != DEPTH) idx++;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    nAssert++;
    if (received != 10 || exp.size() != 0) begin
      nFail++; $display("FAIL wrap_timeout: got %0d records want 10", received);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      setRec(32'h600 + 32'(4 * i));
      tick();
    end
    bus.in_valid = 1'b1;
    setRec(32'h608);
    bus.out_ready = 1'b1;
    nAssert++;
    if ({bus.out_inst, bus.out_pc, bus.out_pc4} !== exp[0] || bus.out_pc !== 32'h600) begin
      nFail++; $display("FAIL b2b_head: got pc=%h want 600", bus.out_pc);
    end
    tick();
    nAssert++;
    if (bus.count !== 3'd2) begin
      nFail++; $display("FAIL b2b_count2: got %0d want 2", bus.count);
    end
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      setRec(32'h60C + 32'(4 * i));
      tick();
    end
    nAssert++;
    if (bus.count !== 3'd4) begin
      nFail++; $display("FAIL b2b_fill: got %0d want 4", bus.count);
    end
    setRec(32'h614);
    bus.out_ready = 1'b1;
    nAssert++;
    if (bus.in_ready !== 1'b0) begin
      nFail++; $display("FAIL b2b_full_ready: got %b want 0", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    nAssert++;
    if (bus.count !== 3'd3) begin
      nFail++; $display("FAIL b2b_full_pop: got %0d want 3", bus.count);
    end
    for (int i = 0; i < 3; i++) begin
      nAssert++;
      if ({bus.out_inst, bus.out_pc, bus.out_pc4} !== exp[0] || bus.out_pc !== 32'h608 + 32'(4 * i)) begin
        nFail++; $display("FAIL b2b_drain_%0d: got pc=%h want %h", i, bus.out_pc, 32'h608 + 32'(4 * i));
      end
      tick();
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      setRec(32'h300 + 32'(4 * i));
      tick();
    end
    setRec(32'h200);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    nAssert++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      nFail++; $display("FAIL flush_empty: got count=%0d valid=%b in_ready=%b want 0 0 1",
                        bus.count, bus.out_valid, bus.in_ready);
    end
    setRec(32'h400);
    tick();
    bus.in_valid = 1'b0;
    nAssert++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h400 || bus.count !== 3'd1
        || {bus.out_inst, bus.out_pc, bus.out_pc4} !== exp[0]) begin
      nFail++; $display("FAIL flush_refill: got valid=%b pc=%h count=%0d want 1 400 1",
                        bus.out_valid, bus.out_pc, bus.count);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      setRec(32'h700 + 32'(4 * i));
      tick();
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    nAssert++;
    if (bus.in_ready !== 1'b0) begin
      nFail++; $display("FAIL rstmid_in_ready_low: got %b want 0", bus.in_ready);
    end
    tick();
    nAssert++;
    if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
      nFail++; $display("FAIL rstmid_cleared: got count=%0d valid=%b want 0 0", bus.count, bus.out_valid);
    end
    rst_n = 1'b1;
    #1;
    nAssert++;
    if (bus.in_ready !== 1'b1) begin
      nFail++; $display("FAIL rstmid_in_ready_high: got %b want 1", bus.in_ready);
    end
    tick();
    nAssert++;
    if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin
      nFail++; $display("FAIL rstmid_no_ghost: got valid=%b count=%0d want 0 0", bus.out_valid, bus.count);
    end
    bus.in_valid = 1'b1;
    setRec(32'h500);
    tick();
    bus.in_valid = 1'b0;
    nAssert++;
    if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h500 || bus.count !== 3'd1) begin
      nFail++; $display("FAIL rstmid_new_head: got valid=%b pc=%h count=%0d want 1 500 1",
                        bus.out_valid, bus.out_pc, bus.count);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_inst = '0;
    bus.in_pc = '0;
    bus.in_pc4 = '0;
    test_reset();
    test_single();
    test_fill_full();
    test_wrap();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
